// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit hex driver for a common-anode seven-segment display, with a debounced page button.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits of the selected half.
module ssd_scan_driver #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        page_btn,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        page
);

  localparam int ScanW = $clog2(SCAN_DIV);
  localparam int DebW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} debState_t;

  logic [ScanW-1:0] scanCnt;
  logic [1:0]       digitIdx;
  logic [31:0]      shadow;
  logic             tick;
  logic             btnMeta, btnSync;
  debState_t        debState, debNext;
  logic [DebW-1:0]  debCnt, debCntNext;
  logic             toggle;
  logic [15:0]      half;
  logic [3:0]       nibble;
  logic             blank;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      4'hF: return 7'h0E;
    endcase
  endfunction

  assign tick = (scanCnt == ScanLast);

  // The shadow word is only refreshed at the 3->0 wrap so one frame always shows one coherent value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scanCnt  <= '0;
      digitIdx <= 2'd0;
      shadow   <= 32'd0;
    end else begin
      scanCnt <= tick ? '0 : scanCnt + ScanW'(1);
      if (tick) begin
        digitIdx <= digitIdx + 2'd1;
        if (digitIdx == 2'd3) shadow <= data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btnMeta  <= 1'b0;
      btnSync  <= 1'b0;
      debState <= IDLE;
      debCnt   <= '0;
      page     <= 1'b0;
    end else begin
      btnMeta  <= page_btn;
      btnSync  <= btnMeta;
      debState <= debNext;
      debCnt   <= debCntNext;
      if (toggle) page <= ~page;
    end
  end

  // Page toggles only on the PRESS_WAIT->HELD edge, so a held button never re-toggles.
  always_comb begin
    debNext    = debState;
    debCntNext = debCnt;
    toggle     = 1'b0;
    case (debState)
      IDLE: begin
        if (btnSync) begin
          debNext    = PRESS_WAIT;
          debCntNext = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btnSync) begin
          debNext = IDLE;
        end else if (debCnt == DebLast) begin
          debNext = HELD;
          toggle  = 1'b1;
        end else begin
          debCntNext = debCnt + DebW'(1);
        end
      end
      HELD: begin
        if (!btnSync) begin
          debNext    = REL_WAIT;
          debCntNext = '0;
        end
      end
      REL_WAIT: begin
        if (btnSync) begin
          debNext = HELD;
        end else if (debCnt == DebLast) begin
          debNext = IDLE;
        end else begin
          debCntNext = debCnt + DebW'(1);
        end
      end
      default: debNext = IDLE;
    endcase
  end

  always_comb begin
    half   = page ? shadow[31:16] : shadow[15:0];
    nibble = half[{digitIdx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank  = (digitIdx != 2'd0) && ((half >> {digitIdx, 2'b00}) == 16'd0);
`else
    blank  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << digitIdx);
      seg <= blank ? 7'h7F : hexToSeg(nibble);
      dp  <= ~((digitIdx == 2'd3) && page);
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver against a cycle-count based reference model.
// Define LEADING_ZERO_BLANK_EN to also exercise leading-zero blanking.
module tb_ssd_scan_driver;

  localparam int SD = 4;
  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic        page_btn = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        page;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] hexSeg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scan_driver #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .page_btn(page_btn),
    .an(an), .seg(seg), .dp(dp), .page(page)
  );

  always #5 clk = ~clk;

  // Reference model: display state derived from the edge count since reset; the button
  // is modelled as run lengths of the twice-delayed sample (DC+1 equal samples to accept a level).
  int          n;
  logic [31:0] mShadow;
  logic        mPage;
  logic        h0, h1, s;
  bit          armed;
  int          runHi, runLo;
  logic [3:0]  expAn;
  logic [6:0]  expSeg;
  logic        expDp;

  always @(posedge clk or posedge reset) begin
    int idx;
    logic [15:0] hv;
    logic [3:0] nib;
    if (reset) begin
      n = 0; mShadow = 32'd0; mPage = 1'b0; h0 = 1'b0; h1 = 1'b0;
      armed = 1'b1; runHi = 0; runLo = 0;
      expAn = 4'b1111; expSeg = 7'h7F; expDp = 1'b1;
    end else begin
      idx    = (n / SD) % 4;
      hv     = mPage ? mShadow[31:16] : mShadow[15:0];
      nib    = 4'(hv >> (4 * idx));
      expAn  = ~(4'b0001 << idx);
      expSeg = hexSeg[nib];
`ifdef LEADING_ZERO_BLANK_EN
      if (idx != 0 && (hv >> (4 * idx)) == 16'd0) expSeg = 7'h7F;
`endif
      expDp  = !(idx == 3 && mPage);
      n++;
      if (n % (4 * SD) == 0) mShadow = data_in;
      s = h1; h1 = h0; h0 = page_btn;
      if (armed) begin
        runHi = s ? runHi + 1 : 0;
        if (runHi == DC + 1) begin mPage = !mPage; armed = 1'b0; runLo = 0; end
      end else begin
        runLo = s ? 0 : runLo + 1;
        if (runLo == DC + 1) begin armed = 1'b1; runHi = 0; end
      end
    end
  end

  task automatic test_reset();
    logic [6:0] frame1 [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
    logic [2:0] d;
    reset = 1'b1; data_in = 32'h1234ABCD; page_btn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({an, seg, dp, page} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_pins: got an=%b seg=%h dp=%b page=%b, want 1111/7f/1/0", an, seg, dp, page);
    end
    reset = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, page} !== {expAn, expSeg, expDp, mPage}) begin
        miscompares++;
        $display("[TB] FAIL first_frame cyc %0d: got an=%b seg=%h dp=%b page=%b, want an=%b seg=%h dp=%b page=%b",
                 c, an, seg, dp, page, expAn, expSeg, expDp, mPage);
      end
      if (n > 16) begin
        case (an)
          4'b1110: d = 3'd0;
          4'b1101: d = 3'd1;
          4'b1011: d = 3'd2;
          4'b0111: d = 3'd3;
          default: d = 3'd4;
        endcase
        vectors++;
        if (d == 3'd4 || seg !== frame1[d[1:0]] || dp !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL dCbA_frame cyc %0d: got an=%b seg=%h dp=%b, want one-hot-low an with d,C,b,A and dp=1",
                   c, an, seg, dp);
        end
      end
    end
  endtask

  task automatic test_page_press();
    int toggleAt = -1;
    page_btn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, page} !== {expAn, expSeg, expDp, mPage}) begin
        miscompares++;
        $display("[TB] FAIL page_press cyc %0d: got an=%b seg=%h dp=%b page=%b, want an=%b seg=%h dp=%b page=%b",
                 c, an, seg, dp, page, expAn, expSeg, expDp, mPage);
      end
      if (page === 1'b1 && toggleAt < 0) toggleAt = c + 1;
      if (c == 19) page_btn = 1'b0;
    end
    vectors++;
    if (toggleAt !== 11 || page !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL page_toggle_latency: got edge %0d page=%b, want edge 11 page=1", toggleAt, page);
    end
  endtask

  task automatic test_bounce();
    int changes = 0;
    int changeAt = -1;
    logic last;
    last = page;
    for (int c = 0; c < 90; c++) begin
      page_btn = (c < 30) ? ((c % 5) < 3) : (c < 50);
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, page} !== {expAn, expSeg, expDp, mPage}) begin
        miscompares++;
        $display("[TB] FAIL bounce cyc %0d: got an=%b seg=%h dp=%b page=%b, want an=%b seg=%h dp=%b page=%b",
                 c, an, seg, dp, page, expAn, expSeg, expDp, mPage);
      end
      if (page !== last) begin
        changes++;
        if (changeAt < 0) changeAt = c;
        last = page;
      end
    end
    vectors++;
    if (changes != 1 || changeAt != 40) begin
      miscompares++;
      $display("[TB] FAIL bounce_toggles: got %0d toggles first at %0d, want 1 at 40", changes, changeAt);
    end
  endtask

  task automatic test_data_change();
    int found = 0;
    int nextWrap;
    data_in = 32'd0;
    repeat (20) @(negedge clk);
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (an === 4'b1101) found = 1;
      else @(negedge clk);
    end
    vectors++;
    if (found == 0) begin
      miscompares++;
      $display("[TB] FAIL data_change_wait: got an=%b, want 1101 within 20 cycles", an);
    end
    data_in = 32'hFFFFFFFF;
    nextWrap = ((n / 16) + 1) * 16;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, page} !== {expAn, expSeg, expDp, mPage}) begin
        miscompares++;
        $display("[TB] FAIL data_change cyc %0d: got an=%b seg=%h dp=%b page=%b, want an=%b seg=%h dp=%b page=%b",
                 c, an, seg, dp, page, expAn, expSeg, expDp, mPage);
      end
      if (n - 1 < nextWrap) begin
        vectors++;
        if (seg !== 7'h40) begin
          miscompares++;
          $display("[TB] FAIL old_frame cyc %0d: got seg=%h, want 40", c, seg);
        end
      end else if (n - 1 < nextWrap + 16) begin
        vectors++;
        if (seg !== 7'h0E) begin
          miscompares++;
          $display("[TB] FAIL new_frame cyc %0d: got seg=%h, want 0e", c, seg);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int found = 0;
    page_btn = 1'b1;
    repeat (15) @(negedge clk);
    page_btn = 1'b0;
    repeat (15) @(negedge clk);
    vectors++;
    if (page !== 1'b1 || mPage !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL page_before_reset: got page=%b, want 1", page);
    end
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (an === 4'b1011) found = 1;
      else @(negedge clk);
    end
    vectors++;
    if (found == 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_wait: got an=%b, want 1011 within 20 cycles", an);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({an, seg, dp, page} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got an=%b seg=%h dp=%b page=%b, want 1111/7f/1/0", an, seg, dp, page);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, page} !== {expAn, expSeg, expDp, mPage} || (c == 0 && an !== 4'b1110)) begin
        miscompares++;
        $display("[TB] FAIL after_reset cyc %0d: got an=%b seg=%h dp=%b page=%b, want an=%b seg=%h dp=%b page=%b",
                 c, an, seg, dp, page, expAn, expSeg, expDp, mPage);
      end
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int c = 0; c < 330; c++) begin
      if (c >= 300) begin
        page_btn = 1'b0;
      end else if (left == 0) begin
        page_btn = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 25);
      end else begin
        left--;
      end
      if ($urandom_range(0, 7) == 0) data_in = $urandom;
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, page} !== {expAn, expSeg, expDp, mPage}) begin
        miscompares++;
        $display("[TB] FAIL random cyc %0d: got an=%b seg=%h dp=%b page=%b, want an=%b seg=%h dp=%b page=%b",
                 c, an, seg, dp, page, expAn, expSeg, expDp, mPage);
      end
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    logic [6:0] expA5 [4] = '{7'h12, 7'h08, 7'h7F, 7'h7F};
    logic [6:0] expZ  [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [2:0] d;
    if (page === 1'b1) begin
      page_btn = 1'b1;
      repeat (15) @(negedge clk);
      page_btn = 1'b0;
      repeat (20) @(negedge clk);
    end
    for (int pass = 0; pass < 2; pass++) begin
      data_in = (pass == 0) ? 32'h000000A5 : 32'd0;
      for (int c = 0; c < 56; c++) begin
        @(negedge clk);
        vectors++;
        if ({an, seg, dp, page} !== {expAn, expSeg, expDp, mPage}) begin
          miscompares++;
          $display("[TB] FAIL blank_model p%0d cyc %0d: got an=%b seg=%h dp=%b page=%b, want an=%b seg=%h dp=%b page=%b",
                   pass, c, an, seg, dp, page, expAn, expSeg, expDp, mPage);
        end
        if (c >= 40) begin
          case (an)
            4'b1110: d = 3'd0;
            4'b1101: d = 3'd1;
            4'b1011: d = 3'd2;
            4'b0111: d = 3'd3;
            default: d = 3'd4;
          endcase
          vectors++;
          if (d == 3'd4 || seg !== (pass == 0 ? expA5[d[1:0]] : expZ[d[1:0]]) || dp !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL blank_digits p%0d cyc %0d: got an=%b seg=%h dp=%b page=%b", pass, c, an, seg, dp, page);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_page_press();
    test_bounce();
    test_data_change();
    test_reset_midframe();
    test_random();
`ifdef LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
